// File: rtl/exu_wb_arb_if.sv
// Writeback arbiter bus: per-channel result handshake in, single registered writeback port out.
interface exu_wb_arb_if #(
    parameter int NUM_CH = 4,
    parameter int XLEN   = 32
);
    logic [NUM_CH-1:0]      ch_valid;
    logic [NUM_CH*XLEN-1:0] ch_data;
    logic [NUM_CH*5-1:0]    ch_rd_addr;
    logic [NUM_CH*XLEN-1:0] ch_tag;
    logic [NUM_CH*32-1:0]   ch_instr;
    logic [NUM_CH-1:0]      ch_ready;

    logic                   wb_rd_wr_en;
    logic [XLEN-1:0]        wb_data;
    logic [4:0]             wb_rd_addr;
    logic [XLEN-1:0]        wb_tag;
    logic [31:0]            wb_instr;
    logic [NUM_CH-1:0]      wb_grant;
    logic                   wb_busy;
    logic                   err_overflow;

    modport master (
        output ch_valid, ch_data, ch_rd_addr, ch_tag, ch_instr,
        input  ch_ready, wb_rd_wr_en, wb_data, wb_rd_addr, wb_tag, wb_instr,
        input  wb_grant, wb_busy, err_overflow
    );

    modport slave (
        input  ch_valid, ch_data, ch_rd_addr, ch_tag, ch_instr,
        output ch_ready, wb_rd_wr_en, wb_data, wb_rd_addr, wb_tag, wb_instr,
        output wb_grant, wb_busy, err_overflow
    );
endinterface

// File: rtl/exu_wb_arb.sv
// Execution-unit writeback arbiter: per-channel FIFOs feeding one registered
// register-file write port, round-robin or fixed-priority selection.
module exu_wb_arb #(
    parameter int NUM_CH  = 4,
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int RR_MODE = 1
) (
    input  logic        clk,
    input  logic        rst,
    exu_wb_arb_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(NUM_CH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0]   data_q  [NUM_CH][DEPTH];
    logic [4:0]        rd_q    [NUM_CH][DEPTH];
    logic [XLEN-1:0]   tag_q   [NUM_CH][DEPTH];
    logic [31:0]       instr_q [NUM_CH][DEPTH];
    logic [PW-1:0]     wptr_q  [NUM_CH];
    logic [PW-1:0]     rptr_q  [NUM_CH];
    logic [CW-1:0]     cnt_q   [NUM_CH];
    logic [IW-1:0]     rr_ptr_q;
    logic              err_q;

    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] not_empty;
    logic [NUM_CH-1:0] store;
    logic [NUM_CH-1:0] pop;
    logic              overflow_hit;
    logic              gnt_vld;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     cand;

    // Ready reflects stored occupancy only; a same-cycle pop never frees a slot.
    always_comb begin
        ready     = '0;
        not_empty = '0;
        store     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ready[i]     = rst || (cnt_q[i] != FULL);
            not_empty[i] = (cnt_q[i] != '0);
            store[i]     = !rst && bus.ch_valid[i] && ready[i]
                           && (bus.ch_rd_addr[i*5 +: 5] != 5'd0);
        end
        overflow_hit = |(bus.ch_valid & ~ready);
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) cand = IW'((int'(rr_ptr_q) + k) % NUM_CH);
            else              cand = IW'(k);
            if (!gnt_vld && not_empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        pop = gnt_vld ? (NUM_CH'(1) << gnt_idx) : '0;
    end

    assign bus.ch_ready     = ready;
    assign bus.err_overflow = err_q;
    assign bus.wb_busy      = (|not_empty) | bus.wb_rd_wr_en;

    // Entry storage carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (store[i]) begin
                data_q[i][wptr_q[i]]  <= bus.ch_data[i*XLEN +: XLEN];
                rd_q[i][wptr_q[i]]    <= bus.ch_rd_addr[i*5 +: 5];
                tag_q[i][wptr_q[i]]   <= bus.ch_tag[i*XLEN +: XLEN];
                instr_q[i][wptr_q[i]] <= bus.ch_instr[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_ptr_q        <= '0;
            err_q           <= 1'b0;
            bus.wb_rd_wr_en <= 1'b0;
            bus.wb_data     <= '0;
            bus.wb_rd_addr  <= '0;
            bus.wb_tag      <= '0;
            bus.wb_instr    <= '0;
            bus.wb_grant    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (store[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
                if (pop[i])   rptr_q[i] <= rptr_q[i] + 1'b1;
                cnt_q[i] <= cnt_q[i] + CW'(store[i]) - CW'(pop[i]);
            end
            if (overflow_hit) err_q <= 1'b1;

            bus.wb_rd_wr_en <= gnt_vld;
            bus.wb_grant    <= pop;
            if (gnt_vld) begin
                bus.wb_data    <= data_q[gnt_idx][rptr_q[gnt_idx]];
                bus.wb_rd_addr <= rd_q[gnt_idx][rptr_q[gnt_idx]];
                bus.wb_tag     <= tag_q[gnt_idx][rptr_q[gnt_idx]];
                bus.wb_instr   <= instr_q[gnt_idx][rptr_q[gnt_idx]];
            end else begin
                bus.wb_data    <= '0;
                bus.wb_rd_addr <= '0;
                bus.wb_tag     <= '0;
                bus.wb_instr   <= '0;
            end

            if (RR_MODE != 0 && gnt_vld)
                rr_ptr_q <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_exu_wb_arb.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus;
// a queue-based model predicts each writeback and the cycle it appears.
module tb_exu_wb_arb;
    localparam int NCH = 4;
    localparam int XL  = 32;
    localparam int DEP = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] tag;
        logic [31:0] instr;
    } ent_t;

    typedef struct packed {
        ent_t        e;
        logic [3:0]  gnt;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exu_wb_arb_if #(.NUM_CH(NCH), .XLEN(XL)) bus_rr();
    exu_wb_arb_if #(.NUM_CH(NCH), .XLEN(XL)) bus_fp();

    exu_wb_arb #(.NUM_CH(NCH), .XLEN(XL), .DEPTH(DEP), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .bus(bus_rr));
    exu_wb_arb #(.NUM_CH(NCH), .XLEN(XL), .DEPTH(DEP), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .bus(bus_fp));

    // Model: index m*NCH+i holds channel i of instance m (0 = round robin, 1 = fixed).
    ent_t fq [2*NCH][$];
    exp_t exp_q [2][$];
    int   rr_ptr [2];
    logic err_m [2];
    logic wb_m [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic           nxt_rst;
    logic [NCH-1:0] nxt_v;
    ent_t           nxt_e [NCH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_state(input int m, input logic [NCH-1:0] rdy, input logic err,
                               input logic busy);
        logic [NCH-1:0] er;
        logic           eb;
        eb = wb_m[m];
        for (int i = 0; i < NCH; i++) begin
            er[i] = rst ? 1'b1 : (fq[m*NCH+i].size() != DEP);
            if (fq[m*NCH+i].size() != 0) eb = 1'b1;
        end
        chk($sformatf("ch_ready[m%0d]", m), 64'(rdy), 64'(er));
        chk($sformatf("err_overflow[m%0d]", m), 64'(err), 64'(err_m[m]));
        chk($sformatf("wb_busy[m%0d]", m), 64'(busy), 64'(eb));
    endtask

    task automatic model_step(input int m);
        int             g;
        int             c;
        logic [NCH-1:0] full;
        exp_t           x;
        if (nxt_rst) begin
            for (int i = 0; i < NCH; i++) fq[m*NCH+i].delete();
            rr_ptr[m] = 0;
            err_m[m]  = 1'b0;
            wb_m[m]   = 1'b0;
            return;
        end
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            c = (m == 0) ? (rr_ptr[m] + k) % NCH : k;
            if (g < 0 && fq[m*NCH+c].size() > 0) g = c;
        end
        for (int i = 0; i < NCH; i++) full[i] = (fq[m*NCH+i].size() == DEP);
        if (g >= 0) begin
            x.e   = fq[m*NCH+g].pop_front();
            x.gnt = 4'(1 << g);
            x.cyc = 32'(cyc + 1);
            exp_q[m].push_back(x);
            if (m == 0) rr_ptr[m] = (g + 1) % NCH;
        end
        wb_m[m] = (g >= 0);
        for (int i = 0; i < NCH; i++) begin
            if (nxt_v[i]) begin
                if (full[i]) err_m[m] = 1'b1;
                else if (nxt_e[i].rd != 5'd0) fq[m*NCH+i].push_back(nxt_e[i]);
            end
        end
    endtask

    task automatic drive_bus();
        rst = nxt_rst;
        bus_rr.ch_valid = nxt_v;
        bus_fp.ch_valid = nxt_v;
        for (int i = 0; i < NCH; i++) begin
            bus_rr.ch_data[i*XL +: XL]   = nxt_e[i].data;
            bus_fp.ch_data[i*XL +: XL]   = nxt_e[i].data;
            bus_rr.ch_rd_addr[i*5 +: 5]  = nxt_e[i].rd;
            bus_fp.ch_rd_addr[i*5 +: 5]  = nxt_e[i].rd;
            bus_rr.ch_tag[i*XL +: XL]    = nxt_e[i].tag;
            bus_fp.ch_tag[i*XL +: XL]    = nxt_e[i].tag;
            bus_rr.ch_instr[i*32 +: 32]  = nxt_e[i].instr;
            bus_fp.ch_instr[i*32 +: 32]  = nxt_e[i].instr;
        end
    endtask

    task automatic do_cycle();
        @(negedge clk);
        check_state(0, bus_rr.ch_ready, bus_rr.err_overflow, bus_rr.wb_busy);
        check_state(1, bus_fp.ch_ready, bus_fp.err_overflow, bus_fp.wb_busy);
        drive_bus();
        model_step(0);
        model_step(1);
    endtask

    task automatic set_idle();
        nxt_rst = 1'b0;
        nxt_v   = '0;
        for (int i = 0; i < NCH; i++) nxt_e[i] = '0;
    endtask

    task automatic set_push(input int ch, input logic [31:0] d, input logic [4:0] rd);
        nxt_v[ch]       = 1'b1;
        nxt_e[ch].data  = d;
        nxt_e[ch].rd    = rd;
        nxt_e[ch].tag   = $urandom;
        nxt_e[ch].instr = $urandom;
    endtask

    task automatic reset_cycle();
        set_idle();
        nxt_rst = 1'b1;
        do_cycle();
        set_idle();
    endtask

    task automatic check_wb(input int m, input logic v, input logic [3:0] gnt,
                            input logic [31:0] d, input logic [4:0] rd,
                            input logic [31:0] tag, input logic [31:0] instr);
        exp_t x;
        while (exp_q[m].size() > 0 && int'(exp_q[m][0].cyc) < cyc) begin
            x = exp_q[m].pop_front();
            chk($sformatf("missed_wb[m%0d]", m), 64'(cyc), 64'(x.cyc));
        end
        if (v) begin
            if (exp_q[m].size() == 0) begin
                chk($sformatf("spurious_wb[m%0d]", m), 64'(v), 64'd0);
            end else begin
                x = exp_q[m].pop_front();
                chk($sformatf("wb_cycle[m%0d]", m), 64'(cyc), 64'(x.cyc));
                chk($sformatf("wb_grant[m%0d]", m), 64'(gnt), 64'(x.gnt));
                chk($sformatf("wb_data[m%0d]", m), 64'(d), 64'(x.e.data));
                chk($sformatf("wb_rd_addr[m%0d]", m), 64'(rd), 64'(x.e.rd));
                chk($sformatf("wb_tag[m%0d]", m), 64'(tag), 64'(x.e.tag));
                chk($sformatf("wb_instr[m%0d]", m), 64'(instr), 64'(x.e.instr));
            end
        end else begin
            chk($sformatf("idle_grant_rd[m%0d]", m), 64'({gnt, rd}), 64'd0);
            chk($sformatf("idle_data_tag[m%0d]", m), {d, tag}, 64'd0);
            chk($sformatf("idle_instr[m%0d]", m), 64'(instr), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        check_wb(0, bus_rr.wb_rd_wr_en, bus_rr.wb_grant, bus_rr.wb_data,
                 bus_rr.wb_rd_addr, bus_rr.wb_tag, bus_rr.wb_instr);
        check_wb(1, bus_fp.wb_rd_wr_en, bus_fp.wb_grant, bus_fp.wb_data,
                 bus_fp.wb_rd_addr, bus_fp.wb_tag, bus_fp.wb_instr);
    end

    initial begin
        int prob;
        for (int m = 0; m < 2; m++) begin
            rr_ptr[m] = 0;
            err_m[m]  = 1'b0;
            wb_m[m]   = 1'b0;
        end
        set_idle();
        nxt_rst = 1'b1;
        drive_bus();
        repeat (3) do_cycle();
        set_idle();
        repeat (4) do_cycle();

        // Single uncontended push.
        set_push(2, 32'hDEADBEEF, 5'd5);
        do_cycle();
        set_idle();
        repeat (4) do_cycle();

        // All channels at once from pointer 0.
        reset_cycle();
        for (int i = 0; i < NCH; i++) set_push(i, $urandom, 5'(i + 1));
        do_cycle();
        set_idle();
        repeat (6) do_cycle();

        // ch0 streams while ch3 holds one entry.
        reset_cycle();
        set_push(0, $urandom, 5'd1);
        set_push(3, $urandom, 5'd3);
        do_cycle();
        for (int n = 0; n < 8; n++) begin
            set_idle();
            set_push(0, $urandom, 5'(n + 2));
            do_cycle();
        end
        set_idle();
        repeat (5) do_cycle();

        // ch1 overfills while ch0 keeps winning.
        reset_cycle();
        for (int n = 0; n < 6; n++) begin
            set_idle();
            set_push(0, $urandom, 5'd7);
            if (n >= 1 && n <= 3) set_push(1, 32'h1000 + n, 5'(n + 10));
            do_cycle();
        end
        set_idle();
        repeat (6) do_cycle();

        // Push to x0 is discarded.
        reset_cycle();
        set_push(3, 32'hCAFE0000, 5'd0);
        do_cycle();
        set_idle();
        repeat (4) do_cycle();

        // Reset with entries queued.
        reset_cycle();
        for (int i = 0; i < NCH; i++) set_push(i, $urandom, 5'(i + 20));
        do_cycle();
        set_idle();
        set_push(0, $urandom, 5'd9);
        set_push(2, $urandom, 5'd8);
        do_cycle();
        reset_cycle();
        repeat (6) do_cycle();

        // Randomised phases of increasing load.
        for (int p = 0; p < 6; p++) begin
            prob = 10 + p * 15;
            for (int n = 0; n < 250; n++) begin
                set_idle();
                nxt_rst = ($urandom_range(0, 199) == 0);
                for (int i = 0; i < NCH; i++)
                    if ($urandom_range(0, 99) < prob)
                        set_push(i, $urandom,
                                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
                do_cycle();
            end
            set_idle();
            repeat (3) do_cycle();
            reset_cycle();
        end

        set_idle();
        repeat (8) do_cycle();
        @(posedge clk);
        #1;
        chk("leftover_expected[m0]", 64'(exp_q[0].size()), 64'd0);
        chk("leftover_expected[m1]", 64'(exp_q[1].size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
